fim_rdack_scfifo: RTL and testbench



---
 rtl/fim_rdack_scfifo_pkg.sv | 16 +
 rtl/fim_rdack_scfifo_ram.sv | 38 +++
 rtl/fim_rdack_scfifo.sv | 131 +++++++++++++
 tb/tb_fim_rdack_scfifo.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fim_rdack_scfifo_pkg.sv
// ---------------------------------------------------------------------------
// fim_rdack_scfifo_pkg
//   Shared helpers for the single-clock read-acknowledge FIFO.
//   almfull_level() turns a depth and an almost-full threshold (free slots)
//   into the occupancy level at which almfull asserts, clamped at zero so an
//   oversized threshold simply keeps almfull permanently high.
// ---------------------------------------------------------------------------
package fim_rdack_scfifo_pkg;

   function automatic int almfull_level(input int depth, input int threshold);
      int lvl;
      lvl = depth - threshold;
      return (lvl < 0) ? 0 : lvl;
   endfunction

endpackage

// File: rtl/fim_rdack_scfifo_ram.sv
// ---------------------------------------------------------------------------
// fim_rdack_fifo_ram
//   Register array backing fim_rdack_scfifo: one synchronous write port and
//   one asynchronous read port, so the head entry is visible the cycle after
//   it is written (show-ahead).
// Ports
//   clk    : write clock
//   we     : write enable (already qualified by full / reset in the parent)
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address
//   rdata  : mem[raddr], combinational
// ---------------------------------------------------------------------------
module fim_rdack_fifo_ram #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // NOTE: the array has no reset; contents are qualified by the parent's
   // count, and leaving it unreset lets the array map onto plain storage.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fim_rdack_scfifo.sv
// ---------------------------------------------------------------------------
// fim_rdack_scfifo
//   Single-clock show-ahead FIFO. The head entry sits on rdata whenever rvalid
//   is high; rdack pops it. Port names mirror the dual-clock rdack FIFO, so the
//   w*/r* status pairs are identical copies of one registered count.
// Parameters
//   DATA_WIDTH            : entry width
//   DEPTH_LOG2            : capacity is 2**DEPTH_LOG2 entries
//   ALMOST_FULL_THRESHOLD : almfull when free slots <= this value
// Ports
//   clk, sclr             : clock, synchronous active-high reset
//   wdata, wreq           : write data / request (dropped while full)
//   rdack                 : pop head entry (ignored while empty)
//   rdata, rvalid         : head entry / FIFO not empty
//   wusedw, rusedw        : occupancy 0..2**DEPTH_LOG2
//   wfull, rfull          : occupancy == 2**DEPTH_LOG2
//   wempty, rempty        : occupancy == 0
//   almfull               : occupancy >= 2**DEPTH_LOG2 - ALMOST_FULL_THRESHOLD
// Configuration
//   FIM_RDACK_FIFO_CHECK_EN : compiles in simulation-only protocol checks
//                             (overflow, underflow, X on controls, count range)
// ---------------------------------------------------------------------------
module fim_rdack_scfifo
   import fim_rdack_scfifo_pkg::*;
#(
   parameter int DATA_WIDTH            = 32,
   parameter int DEPTH_LOG2            = 6,
   parameter int ALMOST_FULL_THRESHOLD = 2
) (
   input  logic                  clk,
   input  logic                  sclr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  wreq,
   input  logic                  rdack,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  rvalid,
   output logic [DEPTH_LOG2:0]   wusedw,
   output logic [DEPTH_LOG2:0]   rusedw,
   output logic                  wfull,
   output logic                  rfull,
   output logic                  wempty,
   output logic                  rempty,
   output logic                  almfull
);

   localparam int CW    = DEPTH_LOG2 + 1;
   localparam int DEPTH = 1 << DEPTH_LOG2;

   localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] AF_LEVEL  = CW'(almfull_level(DEPTH, ALMOST_FULL_THRESHOLD));

   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [CW-1:0]         count;

   logic full;
   logic empty;
   logic we;
   logic re;

   // Status is decoded from the registered count only, so no input reaches
   // an output combinationally.
   assign full  = (count == DEPTH_CNT);
   assign empty = (count == '0);

   assign we = wreq  & ~full;
   assign re = rdack & ~empty;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of its neighbours, independent of statement order.
   always_ff @(posedge clk) begin
      if (sclr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (we) wr_ptr <= wr_ptr + 1'b1;
         if (re) rd_ptr <= rd_ptr + 1'b1;
         unique case ({we, re})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // The array write is masked by sclr so reset wins over a same-cycle write.
   fim_rdack_fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (DEPTH_LOG2)
   ) u_ram (
      .clk   (clk),
      .we    (we & ~sclr),
      .waddr (wr_ptr),
      .wdata (wdata),
      .raddr (rd_ptr),
      .rdata (rdata)
   );

   assign rvalid  = ~empty;
   assign wusedw  = count;
   assign rusedw  = count;
   assign wfull   = full;
   assign rfull   = full;
   assign wempty  = empty;
   assign rempty  = empty;
   assign almfull = (count >= AF_LEVEL);

`ifdef FIM_RDACK_FIFO_CHECK_EN
   longint unsigned chk_cycle;

   always @(posedge clk) begin
      if (sclr) chk_cycle <= 0;
      else      chk_cycle <= chk_cycle + 1;
   end

   always @(posedge clk) begin
      if (!sclr) begin
         assert (!$isunknown({wreq, rdack}))
            else $error("%m: X on wreq/rdack at cycle %0d", chk_cycle);
         assert (!(wreq === 1'b1 && full))
            else $error("%m: overflow, wreq while full at cycle %0d", chk_cycle);
         assert (!(rdack === 1'b1 && empty))
            else $error("%m: underflow, rdack while empty at cycle %0d", chk_cycle);
         assert (count <= DEPTH_CNT)
            else $error("%m: count %0d exceeds depth at cycle %0d", count, chk_cycle);
      end
   end
`endif

endmodule

// File: tb/tb_fim_rdack_scfifo.sv
// ---------------------------------------------------------------------------
// tb_fim_rdack_scfifo
//   Self-checking bench for fim_rdack_scfifo (default parameters). A queue
//   models the FIFO contents; every expected output is derived from it.
// ---------------------------------------------------------------------------
module tb_fim_rdack_scfifo;

   localparam int DW    = 32;
   localparam int DEPTH = 64;
   localparam int AF    = 2;

   logic          clk = 1'b0;
   logic          sclr;
   logic [DW-1:0] wdata;
   logic          wreq;
   logic          rdack;
   logic [DW-1:0] rdata;
   logic          rvalid;
   logic [6:0]    wusedw;
   logic [6:0]    rusedw;
   logic          wfull;
   logic          rfull;
   logic          wempty;
   logic          rempty;
   logic          almfull;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] q [$];

   fim_rdack_scfifo dut (
      .clk     (clk),
      .sclr    (sclr),
      .wdata   (wdata),
      .wreq    (wreq),
      .rdack   (rdack),
      .rdata   (rdata),
      .rvalid  (rvalid),
      .wusedw  (wusedw),
      .rusedw  (rusedw),
      .wfull   (wfull),
      .rfull   (rfull),
      .wempty  (wempty),
      .rempty  (rempty),
      .almfull (almfull)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
         else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
         end
   endtask

   // Compare every output against the model queue.
   task automatic check_state(input string tag);
      int n;
      n = q.size();
      check({tag, ":rvalid"},  64'(rvalid),  64'(n > 0));
      check({tag, ":wusedw"},  64'(wusedw),  64'(n));
      check({tag, ":rusedw"},  64'(rusedw),  64'(n));
      check({tag, ":wfull"},   64'(wfull),   64'(n == DEPTH));
      check({tag, ":rfull"},   64'(rfull),   64'(n == DEPTH));
      check({tag, ":wempty"},  64'(wempty),  64'(n == 0));
      check({tag, ":rempty"},  64'(rempty),  64'(n == 0));
      check({tag, ":almfull"}, 64'(almfull), 64'(DEPTH - n <= AF));
      if (n > 0) check({tag, ":rdata"}, 64'(rdata), 64'(q[0]));
   endtask

   // Drive one cycle of inputs (from a negedge), update the model at the
   // posedge, then check outputs at the following negedge.
   task automatic step(input string tag, input logic w, input logic [DW-1:0] d,
                       input logic r, input logic clr = 1'b0);
      bit do_w;
      bit do_r;
      wreq  = w;
      wdata = d;
      rdack = r;
      sclr  = clr;
      @(posedge clk);
      if (clr) begin
         q.delete();
      end else begin
         do_w = w && (q.size() < DEPTH);
         do_r = r && (q.size() > 0);
         if (do_r) void'(q.pop_front());
         if (do_w) q.push_back(d);
      end
      @(negedge clk);
      wreq  = 1'b0;
      rdack = 1'b0;
      sclr  = 1'b0;
      check_state(tag);
   endtask

   initial begin
      sclr  = 1'b1;
      wreq  = 1'b0;
      rdack = 1'b0;
      wdata = '0;
      @(negedge clk);

      // Reset, then idle for 10 cycles.
      step("reset", 1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) step("idle", 1'b0, '0, 1'b0);

      // Write 1..5, then pop 5.
      for (int i = 1; i <= 5; i++) begin
         step("wr5", 1'b1, DW'(i), 1'b0);
         if (i == 1) check("wr5:first_valid", 64'(rvalid), 64'd1);
      end
      check("wr5:peak", 64'(wusedw), 64'd5);
      for (int i = 1; i <= 5; i++) begin
         check("rd5:data", 64'(rdata), 64'(i));
         step("rd5", 1'b0, '0, 1'b1);
      end

      // Fill to full, overflow write dropped, then drain.
      for (int i = 0; i < DEPTH; i++) begin
         step("fill", 1'b1, DW'(i), 1'b0);
         if (i == DEPTH - AF - 2) check("fill:af_low",  64'(almfull), 64'd0);
         if (i == DEPTH - AF - 1) check("fill:af_rise", 64'(almfull), 64'd1);
         if (i == DEPTH - 2)      check("fill:not_full", 64'(wfull), 64'd0);
      end
      check("fill:full", 64'(rfull), 64'd1);
      step("overflow", 1'b1, 32'hDEAD, 1'b0);
      check("overflow:usedw", 64'(wusedw), 64'(DEPTH));
      for (int i = 0; i < DEPTH; i++) begin
         check("drain:data", 64'(rdata), 64'(i));
         step("drain", 1'b0, '0, 1'b1);
      end
      check("drain:empty", 64'(rempty), 64'd1);

      // Full with simultaneous wreq+rdack: only the pop happens.
      for (int i = 0; i < DEPTH; i++) step("refill", 1'b1, DW'(i + 100), 1'b0);
      step("full_both", 1'b1, 32'hBEEF, 1'b1);
      check("full_both:usedw", 64'(wusedw), 64'(DEPTH - 1));
      for (int i = 0; i < DEPTH - 1; i++) step("drain2", 1'b0, '0, 1'b1);

      // Steady state at count 3 with simultaneous push/pop, wrapping pointers.
      for (int i = 0; i < 3; i++) step("pre3", 1'b1, DW'(1000 + i), 1'b0);
      for (int i = 0; i < 200; i++) begin
         check("stream:head", 64'(rdata), 64'(1000 + i));
         step("stream", 1'b1, DW'(1003 + i), 1'b1);
      end
      check("stream:usedw", 64'(rusedw), 64'd3);
      for (int i = 0; i < 3; i++) step("post3", 1'b0, '0, 1'b1);

      // Underflow ignored; simultaneous push/pop while empty writes only.
      step("underflow", 1'b0, '0, 1'b1);
      check("underflow:usedw", 64'(wusedw), 64'd0);
      step("empty_both", 1'b1, 32'h1234_5678, 1'b1);
      check("empty_both:usedw", 64'(wusedw), 64'd1);
      check("empty_both:rdata", 64'(rdata), 64'h1234_5678);
      step("pop1", 1'b0, '0, 1'b1);

      // sclr with 10 entries held, with a same-cycle write, then reuse.
      for (int i = 0; i < 10; i++) step("pre_clr", 1'b1, DW'(i + 500), 1'b0);
      step("sclr", 1'b1, 32'hCAFE, 1'b1, 1'b1);
      check("sclr:usedw", 64'(wusedw), 64'd0);
      check("sclr:rvalid", 64'(rvalid), 64'd0);
      step("post_clr_wr", 1'b1, 32'hA5A5_0001, 1'b0);
      check("post_clr:rdata", 64'(rdata), 64'hA5A5_0001);
      step("post_clr_rd", 1'b0, '0, 1'b1);

      // Randomized traffic with phases biased toward full and toward empty.
      for (int ph = 0; ph < 6; ph++) begin
         int pw;
         pw = (ph % 2 == 0) ? 85 : 20;
         for (int i = 0; i < 120; i++) begin
            logic w;
            logic r;
            logic c;
            w = ($urandom_range(0, 99) < pw);
            r = ($urandom_range(0, 99) < (100 - pw));
            c = ($urandom_range(0, 299) == 0);
            step("rand", w, DW'($urandom), r, c);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
